// File: rtl/v_hier_pkg.sv
// Shared types for the qvec change monitor: FSM state encoding and the
// event record that travels through the event FIFO.
package v_hier_pkg;

    // Default widths of the monitored vector and of the stamp/counter fields.
    // The event record below is laid out with these values, so the top-level
    // parameters default to them.
    localparam int MON_WIDTH = 4;
    localparam int MON_CNT_W = 8;

    // Monitor sequencing: IDLE (off), ARM (take baseline), RUN (detect).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } mon_state_e;

    // One detected change: value after the change, changed bits, timestamp.
    typedef struct packed {
        logic [MON_WIDTH-1:0] data;
        logic [MON_WIDTH-1:0] mask;
        logic [MON_CNT_W-1:0] stamp;
    } mon_evt_t;

endpackage

// File: rtl/v_hier_evt_fifo.sv
// Synchronous event FIFO. Pointers carry one extra wrap bit so that full
// and empty are distinguished without an occupancy counter. The head entry
// is presented combinationally on rdata. flush empties the FIFO and wins
// over push and pop in the same cycle.
module v_hier_evt_fifo
    import v_hier_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset_l,
    input  logic     flush,
    input  logic     push,
    input  logic     pop,
    input  mon_evt_t wdata,
    output mon_evt_t rdata,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    mon_evt_t    mem [DEPTH];

    // Read/write pointers; flush returns both to the start.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change behaviour.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage, written at the tail on push.
    // NOTE: the array has no reset; an entry is only ever read after it has
    // been written, and the top masks the head while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/v_hier_qvec_mon.sv
// qvec change monitor. Samples qvec every clock; once armed, every cycle in
// which qvec differs from the previous sample queues one event
// {new value, changed bits, timestamp}. Events drain over a valid/ready
// stream. Also keeps a saturating change counter and a sticky overflow flag
// for events dropped while the FIFO was full.
module v_hier_qvec_mon
    import v_hier_pkg::*;
#(
    parameter int WIDTH = MON_WIDTH,
    parameter int CNT_W = MON_CNT_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic [WIDTH-1:0] qvec,
    input  logic             enable,
    input  logic             clear,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_data,
    output logic [WIDTH-1:0] evt_mask,
    output logic [CNT_W-1:0] evt_stamp,
    output logic [CNT_W-1:0] chg_count,
    output logic             overflow
);

    mon_state_e       state;
    logic [WIDTH-1:0] q_d;
    logic [CNT_W-1:0] stamp_cnt;
    mon_evt_t         last_evt;
    mon_evt_t         new_evt;
    mon_evt_t         head_evt;
    mon_evt_t         evt_view;

    logic chg;
    logic push_req;
    logic pop;
    logic fifo_push;
    logic fifo_full;
    logic fifo_empty;
    logic drop;

    // A change is only recognised in RUN while still enabled; the cycle
    // enable falls is treated as leaving RUN and reports nothing.
    assign chg       = (state == RUN) && enable && (qvec != q_d);
    assign push_req  = chg && !clear;
    assign evt_valid = !fifo_empty;
    assign pop       = evt_valid && evt_ready;
    // A full FIFO still accepts the new event when the head leaves that cycle.
    assign fifo_push = push_req && (!fifo_full || pop);
    assign drop      = push_req && fifo_full && !pop;

    // Assemble the event record for the current cycle.
    // NOTE: every field gets a value on every path through always_comb, which
    // keeps the block purely combinational with no inferred latch.
    always_comb begin
        new_evt       = '0;
        new_evt.data  = qvec;
        new_evt.mask  = qvec ^ q_d;
        new_evt.stamp = stamp_cnt;
    end

    // Monitor sequencing and baseline capture; clear leaves both untouched.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            q_d   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    q_d   <= qvec;
                    state <= enable ? RUN : IDLE;
                end
                RUN: begin
                    q_d <= qvec;
                    if (!enable) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Free-running timestamp, wraps naturally; clear restarts it at zero.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stamp_cnt <= '0;
        end else if (clear) begin
            stamp_cnt <= '0;
        end else begin
            stamp_cnt <= stamp_cnt + 1'b1;
        end
    end

    // Change counter: counts every detected change, dropped or not, and
    // holds once it reaches all-ones.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            chg_count <= '0;
        end else if (clear) begin
            chg_count <= '0;
        end else if (chg && !(&chg_count)) begin
            chg_count <= chg_count + 1'b1;
        end
    end

    // Sticky overflow: set when an event is lost to a full FIFO.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Remember the most recently consumed event so the outputs hold it
    // while the FIFO is empty.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            last_evt <= '0;
        end else if (pop && !clear) begin
            last_evt <= head_evt;
        end
    end

    v_hier_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .flush   (clear),
        .push    (fifo_push),
        .pop     (pop && !clear),
        .wdata   (new_evt),
        .rdata   (head_evt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Present the head while events are queued, otherwise the last one taken.
    assign evt_view  = fifo_empty ? last_evt : head_evt;
    assign evt_data  = evt_view.data;
    assign evt_mask  = evt_view.mask;
    assign evt_stamp = evt_view.stamp;

endmodule

// File: tb/tb_v_hier_qvec_mon.sv
// Self-checking bench for v_hier_qvec_mon. A transaction-level model (event
// queue, enable streak, counters) predicts every output after each clock.
module tb_v_hier_qvec_mon;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_l;
    logic [WIDTH-1:0] qvec;
    logic             enable;
    logic             clear;
    logic             evt_valid;
    logic             evt_ready;
    logic [WIDTH-1:0] evt_data;
    logic [WIDTH-1:0] evt_mask;
    logic [CNT_W-1:0] evt_stamp;
    logic [CNT_W-1:0] chg_count;
    logic             overflow;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int data;
        int mask;
        int stamp;
    } ev_t;

    ev_t m_q[$];
    ev_t m_last;
    int  m_stamp;
    int  m_cnt;
    int  m_ovf;
    int  m_streak;
    int  m_prev;

    v_hier_qvec_mon #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .qvec      (qvec),
        .enable    (enable),
        .clear     (clear),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_mask  (evt_mask),
        .evt_stamp (evt_stamp),
        .chg_count (chg_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last   = '{0, 0, 0};
        m_stamp  = 0;
        m_cnt    = 0;
        m_ovf    = 0;
        m_streak = 0;
        m_prev   = 0;
    endtask

    // Detection needs enable high on this and the two previous edges
    // (enter, take baseline, compare); the baseline is the previous sample.
    task automatic model_edge();
        bit  pop;
        bit  chg;
        int  qv;
        qv  = int'(qvec);
        pop = evt_ready && (m_q.size() > 0);
        if (enable) m_streak = (m_streak < 3) ? m_streak + 1 : 3;
        else        m_streak = 0;
        chg = enable && (m_streak >= 3) && (qv != m_prev);
        if (clear) begin
            m_q.delete();
            m_cnt   = 0;
            m_ovf   = 0;
            m_stamp = 0;
        end else begin
            if (pop) m_last = m_q.pop_front();
            if (chg) begin
                if (m_cnt < 255) m_cnt++;
                if (m_q.size() < DEPTH) m_q.push_back('{qv, qv ^ m_prev, m_stamp});
                else m_ovf = 1;
            end
            m_stamp = (m_stamp + 1) % 256;
        end
        m_prev = qv;
    endtask

    task automatic check_all(input string tag);
        ev_t h;
        int  v;
        v = (m_q.size() > 0) ? 1 : 0;
        h = v ? m_q[0] : m_last;
        check({tag, ".valid"}, 32'(evt_valid), v);
        check({tag, ".data"},  32'(evt_data),  h.data);
        check({tag, ".mask"},  32'(evt_mask),  h.mask);
        check({tag, ".stamp"}, 32'(evt_stamp), h.stamp);
        check({tag, ".count"}, 32'(chg_count), m_cnt);
        check({tag, ".ovf"},   32'(overflow),  m_ovf);
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int  n;
        int  prev_obs;
        bit  seen_wrap;

        reset_l   = 1'b0;
        qvec      = '0;
        enable    = 1'b0;
        clear     = 1'b0;
        evt_ready = 1'b0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        reset_l = 1'b1;
        #1;
        check_all("reset_rel");

        // 1: enabled with a constant vector -> arm, run, no events
        enable    = 1'b1;
        evt_ready = 1'b1;
        repeat (10) cyc("s1");
        check("s1_count", 32'(chg_count), 0);

        // 2: first change lands at stamp 10
        qvec = 4'h5;
        cyc("s2");
        check("s2_valid", 32'(evt_valid), 1);
        check("s2_data",  32'(evt_data),  5);
        check("s2_mask",  32'(evt_mask),  5);
        check("s2_stamp", 32'(evt_stamp), 10);
        check("s2_count", 32'(chg_count), 1);
        cyc("s2_pop");

        // 3: five changes into a stalled four-deep FIFO
        clear = 1'b1;
        cyc("s3_clr");
        clear     = 1'b0;
        evt_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            qvec = 4'(5 + i);
            cyc("s3_fill");
        end
        check("s3_ovf",   32'(overflow),  1);
        check("s3_count", 32'(chg_count), 5);
        evt_ready = 1'b1;
        repeat (5) cyc("s3_drain");

        // 4: full FIFO, change and pop in the same cycle -> nothing lost
        clear = 1'b1;
        cyc("s4_clr");
        clear     = 1'b0;
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            qvec = 4'(11 + i);
            cyc("s4_fill");
        end
        evt_ready = 1'b1;
        qvec      = 4'hF;
        cyc("s4_pushpop");
        check("s4_ovf", 32'(overflow), 0);
        n = 0;
        repeat (6) begin
            if (evt_valid) n++;
            cyc("s4_drain");
        end
        check("s4_occupancy", 32'(n), 4);

        // 5: clear with three queued and a change in the same cycle
        evt_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            qvec = 4'(i);
            cyc("s5_fill");
        end
        clear = 1'b1;
        qvec  = 4'h4;
        cyc("s5_clr");
        check("s5_valid", 32'(evt_valid), 0);
        check("s5_count", 32'(chg_count), 0);
        check("s5_ovf",   32'(overflow),  0);
        clear = 1'b0;
        qvec  = 4'h5;
        cyc("s5_after");
        check("s5_stamp0", 32'(evt_stamp), 0);
        check("s5_mask",   32'(evt_mask),  1);
        evt_ready = 1'b1;
        repeat (2) cyc("s5_drain");

        // 6: disable, wander, re-enable on a new value -> no baseline event
        enable = 1'b0;
        cyc("s6_off");
        qvec = 4'h3;
        cyc("s6_off");
        qvec = 4'hC;
        cyc("s6_off");
        enable = 1'b1;
        qvec   = 4'h9;
        repeat (3) cyc("s6_rearm");
        check("s6_noevt", 32'(evt_valid), 0);
        evt_ready = 1'b0;
        qvec      = 4'hF;
        cyc("s6_change");
        check("s6_mask", 32'(evt_mask), 6);
        evt_ready = 1'b1;
        cyc("s6_drain");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) qvec = 4'($urandom);
            enable    = ($urandom_range(0, 15) != 0);
            evt_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 30) == 0);
            cyc("rand");
        end

        // 7: asynchronous reset in the middle of draining
        enable    = 1'b1;
        clear     = 1'b0;
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            qvec = 4'(i + 1);
            cyc("s7_fill");
        end
        evt_ready = 1'b1;
        cyc("s7_drain");
        #2;
        reset_l = 1'b0;
        #1;
        model_reset();
        check_all("s7_async");
        check("s7_valid0", 32'(evt_valid), 0);
        @(negedge clk);
        reset_l = 1'b1;
        #1;
        check_all("s7_rel");

        // 8: continuous toggling -> stamp wrap and counter saturation
        enable    = 1'b1;
        evt_ready = 1'b1;
        qvec      = 4'h0;
        prev_obs  = -1;
        seen_wrap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            qvec = ~qvec;
            cyc("s8");
            if (evt_valid && prev_obs == 255 && int'(evt_stamp) == 0) seen_wrap = 1'b1;
            if (evt_valid) prev_obs = int'(evt_stamp);
        end
        check("s8_wrap",  32'(seen_wrap), 1);
        check("s8_count", 32'(chg_count), 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
